// File: rtl/sobel_edge_if.sv
// Video stream bundle between the gray test-pattern source and the Sobel stage.
// The source drives the i* timing/pixel signals; the stage returns the delayed o* stream.
interface sobel_edge_if;
    logic       iHs;
    logic       iVs;
    logic       iDe;
    logic [7:0] iGray;
    logic       oHs;
    logic       oVs;
    logic       oDe;
    logic [7:0] oPix;

    modport master (
        output iHs, iVs, iDe, iGray,
        input  oHs, oVs, oDe, oPix
    );

    modport slave (
        input  iHs, iVs, iDe, iGray,
        output oHs, oVs, oDe, oPix
    );
endinterface

// File: rtl/sobel_edge.sv
// Streaming 3x3 Sobel edge stage, fixed 3-cycle latency on pixels and timing.
// Define SOBEL_BINARY_EN for thresholded binary output instead of saturated magnitude.
module sobel_edge #(
    parameter int         MAX_W  = 1024,
    parameter logic [7:0] THRESH = 8'd64
) (
    input  logic         video_clk,
    input  logic         rst_n,
    sobel_edge_if.slave  vid
);

    localparam int               COL_W   = $clog2(MAX_W + 1);
    localparam int               ADDR_W  = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(MAX_W);
    localparam logic [10:0]      ROW_MAX = 11'd2047;

    logic [COL_W-1:0] col;
    logic [10:0]      row;
    logic             de_prev;

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            col     <= '0;
            row     <= '0;
            de_prev <= 1'b0;
        end else begin
            de_prev <= vid.iDe;
            if (!vid.iDe)
                col <= '0;
            else if (col != COL_MAX)
                col <= col + 1'b1;
            if (!vid.iVs)
                row <= '0;
            else if (de_prev && !vid.iDe && row != ROW_MAX)
                row <= row + 11'd1;
        end
    end

    // Line buffers: combinational read of the old entry, write at the edge,
    // so each store sees the value from the previous line.
    logic [7:0]        lb0 [0:MAX_W-1];
    logic [7:0]        lb1 [0:MAX_W-1];
    logic              in_range;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        lb0_rd;
    logic [7:0]        lb1_rd;

    assign in_range = (col < COL_MAX);
    assign addr     = col[ADDR_W-1:0];
    assign lb0_rd   = in_range ? lb0[addr] : 8'd0;
    assign lb1_rd   = in_range ? lb1[addr] : 8'd0;

    always_ff @(posedge video_clk) begin
        if (vid.iDe && in_range) begin
            lb0[addr] <= vid.iGray;
            lb1[addr] <= lb0[addr];
        end
    end

    logic [7:0] p11, p12, p13;
    logic [7:0] p21, p22, p23;
    logic [7:0] p31, p32, p33;
    logic       s1_hs, s1_vs, s1_de, s1_border;
    logic       border;

    assign border = (row < 11'd2) || (col < COL_W'(2)) || !in_range;

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            p11 <= '0; p12 <= '0; p13 <= '0;
            p21 <= '0; p22 <= '0; p23 <= '0;
            p31 <= '0; p32 <= '0; p33 <= '0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            s1_de     <= 1'b0;
            s1_border <= 1'b1;
        end else begin
            if (vid.iDe) begin
                p11 <= p12; p12 <= p13; p13 <= lb1_rd;
                p21 <= p22; p22 <= p23; p23 <= lb0_rd;
                p31 <= p32; p32 <= p33; p33 <= vid.iGray;
            end
            s1_hs     <= vid.iHs;
            s1_vs     <= vid.iVs;
            s1_de     <= vid.iDe;
            s1_border <= border;
        end
    end

    logic [9:0]         gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [10:0] gx, gy;
    logic               s2_hs, s2_vs, s2_de, s2_border;

    assign gx_pos = {2'b00, p13} + {1'b0, p23, 1'b0} + {2'b00, p33};
    assign gx_neg = {2'b00, p11} + {1'b0, p21, 1'b0} + {2'b00, p31};
    assign gy_pos = {2'b00, p31} + {1'b0, p32, 1'b0} + {2'b00, p33};
    assign gy_neg = {2'b00, p11} + {1'b0, p12, 1'b0} + {2'b00, p13};

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            gx        <= '0;
            gy        <= '0;
            s2_hs     <= 1'b0;
            s2_vs     <= 1'b0;
            s2_de     <= 1'b0;
            s2_border <= 1'b1;
        end else begin
            gx        <= $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
            gy        <= $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
            s2_hs     <= s1_hs;
            s2_vs     <= s1_vs;
            s2_de     <= s1_de;
            s2_border <= s1_border;
        end
    end

    // |G| never exceeds 1020 per axis, so 12 bits hold the sum without wrap.
    logic [10:0] abs_gx, abs_gy;
    logic [11:0] mag;
    logic [7:0]  pix_val;

    assign abs_gx = gx[10] ? (~gx + 11'd1) : gx;
    assign abs_gy = gy[10] ? (~gy + 11'd1) : gy;
    assign mag    = {1'b0, abs_gx} + {1'b0, abs_gy};

`ifdef SOBEL_BINARY_EN
    assign pix_val = (mag >= {4'b0000, THRESH}) ? 8'hFF : 8'h00;
`else
    assign pix_val = (mag > 12'd255) ? 8'hFF : mag[7:0];
`endif

    logic       hs_q, vs_q, de_q;
    logic [7:0] pix_q;

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            de_q  <= 1'b0;
            pix_q <= 8'd0;
        end else begin
            hs_q  <= s2_hs;
            vs_q  <= s2_vs;
            de_q  <= s2_de;
            pix_q <= (s2_de && !s2_border) ? pix_val : 8'd0;
        end
    end

    assign vid.oHs  = hs_q;
    assign vid.oVs  = vs_q;
    assign vid.oDe  = de_q;
    assign vid.oPix = pix_q;

endmodule

// File: tb/tb_sobel_edge.sv
// Scoreboard bench for sobel_edge: frames are stored in an image array and the
// expected pixel is computed straight from the 3x3 Sobel definition.
module tb_sobel_edge;

    localparam int         MAX_W  = 1024;
    localparam logic [7:0] THRESH = 8'd64;
    localparam int         IMG_R  = 64;
    localparam int         IMG_C  = 1040;

    logic video_clk = 1'b0;
    logic rst_n     = 1'b0;

    sobel_edge_if vif ();

    sobel_edge #(
        .MAX_W  (MAX_W),
        .THRESH (THRESH)
    ) dut (
        .video_clk (video_clk),
        .rst_n     (rst_n),
        .vid       (vif)
    );

    always #5 video_clk = ~video_clk;

    logic [7:0] img [0:IMG_R-1][0:IMG_C-1];
    logic [8:0] exp_q [$];
    logic [7:0] drv_exp  = 8'd0;
    logic       drv_care = 1'b0;
    logic [2:0] h0 = 3'b000, h1 = 3'b000, h2 = 3'b000;
    int         rst_hold = 0;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] ref_pix(input int r, input int c);
        int t [3][3];
        int gx, gy, mag;
        if (r < 2 || c < 2 || c >= MAX_W) return 8'd0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                t[i][j] = int'(img[r-2+i][c-2+j]);
        gx = (t[0][2] + 2*t[1][2] + t[2][2]) - (t[0][0] + 2*t[1][0] + t[2][0]);
        gy = (t[2][0] + 2*t[2][1] + t[2][2]) - (t[0][0] + 2*t[0][1] + t[0][2]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_BINARY_EN
        return (mag >= int'(THRESH)) ? 8'hFF : 8'h00;
`else
        return (mag > 255) ? 8'hFF : 8'(mag);
`endif
    endfunction

    function automatic logic [7:0] gen_pix(input int kind, input int c);
        case (kind)
            0:       return 8'd100;
            1:       return (c < 25) ? 8'd0 : 8'd200;
            2:       return 8'(4 * c);
            default: return 8'($urandom);
        endcase
    endfunction

    // Input sampler: records timing for the delay model and queues expected pixels.
    always @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            h0 <= 3'b000;
            h1 <= 3'b000;
            h2 <= 3'b000;
            exp_q.delete();
        end else begin
            h0 <= {vif.iHs, vif.iVs, vif.iDe};
            h1 <= h0;
            h2 <= h1;
            if (vif.iDe) exp_q.push_back({drv_care, drv_exp});
        end
    end

    // Monitor: timing outputs against the 3-stage delay, pixels against the queue.
    always @(negedge video_clk) begin
        logic [8:0] e;
        checkOutput("oHs", vif.oHs, h2[2]);
        checkOutput("oVs", vif.oVs, h2[1]);
        checkOutput("oDe", vif.oDe, h2[0]);
        if (vif.oDe) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL pix_queue: got oDe=1, expected no pixel pending at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (e[8]) checkOutput("oPix", vif.oPix, e[7:0]);
            end
        end else begin
            checkOutput("oPix_blank", vif.oPix, 0);
        end
    end

    task automatic applyStimulus(input logic hs, input logic vs, input logic de,
                                 input logic [7:0] gray, input logic [7:0] expv,
                                 input logic care);
        vif.iHs  = hs;
        vif.iVs  = vs;
        vif.iDe  = de;
        vif.iGray = gray;
        drv_exp  = expv;
        drv_care = care;
        @(posedge video_clk);
        #1;
        if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) rst_n = 1'b1;
        end
    endtask

    task automatic run_frame(input int kind, input int h, input int w, input logic care,
                             input int rst_r, input int rst_c);
        logic [7:0] g;
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        for (int r = 0; r < h; r++) begin
            for (int i = 0; i < 12; i++) applyStimulus(i < 3, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
            for (int c = 0; c < w; c++) begin
                g = gen_pix(kind, c);
                img[r][c] = g;
                if (r == rst_r && c == rst_c) begin
                    rst_n = 1'b0;
                    #1;
                    checkOutput("midrst_oHs", vif.oHs, 0);
                    checkOutput("midrst_oVs", vif.oVs, 0);
                    checkOutput("midrst_oDe", vif.oDe, 0);
                    checkOutput("midrst_oPix", vif.oPix, 0);
                    rst_hold = 3;
                end
                applyStimulus(1'b0, 1'b1, 1'b1, g, ref_pix(r, c), care);
            end
        end
        for (int i = 0; i < 12; i++) applyStimulus(i < 3, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    endtask

    initial begin
        vif.iHs   = 1'b0;
        vif.iVs   = 1'b0;
        vif.iDe   = 1'b0;
        vif.iGray = 8'd0;
        repeat (3) @(posedge video_clk);
        @(negedge video_clk);
        checkOutput("rst_oHs", vif.oHs, 0);
        checkOutput("rst_oVs", vif.oVs, 0);
        checkOutput("rst_oDe", vif.oDe, 0);
        checkOutput("rst_oPix", vif.oPix, 0);
        @(posedge video_clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] flat frame");
        run_frame(0, 50, 50, 1'b1, -1, -1);
        $display("[TB] vertical step");
        run_frame(1, 50, 50, 1'b1, -1, -1);
        $display("[TB] horizontal ramp");
        run_frame(2, 50, 50, 1'b1, -1, -1);
        $display("[TB] random frame");
        run_frame(3, 20, 40, 1'b1, -1, -1);
        $display("[TB] reset mid-line, then clean frame");
        run_frame(3, 10, 30, 1'b0, 5, 10);
        run_frame(3, 20, 40, 1'b1, -1, -1);
        $display("[TB] over-wide lines");
        run_frame(3, 4, 1030, 1'b1, -1, -1);
        run_frame(3, 6, 60, 1'b1, -1, -1);

        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
        checkOutput("queue_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_edge.md
Name: sobel_edge

Overview:
- Streaming 3x3 Sobel edge stage that sits directly downstream of the grayscale test-pattern source in the video testbench.
- Consumes the source's hs/vs/de timing and 8-bit gray pixel stream.
- Builds a 3x3 window from two line buffers and computes |Gx|+|Gy|.
- Emits either a saturated gradient magnitude or a thresholded binary edge pixel, with timing signals delayed to match.

Parameters:
- MAX_W, 1024: line-buffer depth; maximum active pixels per line.
- THRESH, 8'd64: edge threshold used in binary mode.

Ports:
- video_clk  input  1  pixel clock.
- rst_n  input  1  asynchronous active-low reset.
- iHs  input  1  horizontal sync from the upstream source.
- iVs  input  1  vertical sync; low = vertical blanking.
- iDe  input  1  active-pixel strobe.
- iGray  input  8  gray pixel, valid when iDe=1.
- oHs  output  1  iHs delayed 3 cycles.
- oVs  output  1  iVs delayed 3 cycles.
- oDe  output  1  iDe delayed 3 cycles.
- oPix  output  8  result pixel, valid when oDe=1.

Behaviour:
- Reset (async, rst_n=0):
  - oHs, oVs, oDe, oPix = 0.
  - Column and row counters = 0.
  - Window registers = 0.
  - Line-buffer contents are don't-care; the row counter gating masks them.
- Column counter col:
  - Increments on each iDe=1 cycle.
  - Clears on any cycle with iDe=0.
  - Saturates at MAX_W.
- Row counter row:
  - Increments on each iDe falling edge.
  - Clears while iVs=0.
  - Saturates at 2047.
- Line buffers:
  - LB0 holds the previous line, LB1 holds the line before that.
  - On iDe with col<MAX_W: read LB0[col] and LB1[col]; write LB1[col]<=LB0[col] and LB0[col]<=iGray in the same cycle (read-before-write).
  - Pixels with col>=MAX_W are not stored.
- Window: a 3x3 shift register. Each iDe cycle shifts left and loads the column {LB1 read, LB0 read, iGray} as the right column (p13, p23, p33).
- Pipeline, fixed latency 3 cycles from input to oPix/oDe:
  - S1: window update.
  - S2: Gx and Gy.
  - S3: magnitude, saturation/threshold, output register.
- Arithmetic:
  - Gx = (p13 + 2·p23 + p33) − (p11 + 2·p21 + p31), signed 11-bit.
  - Gy = (p31 + 2·p32 + p33) − (p11 + 2·p12 + p13), signed 11-bit.
  - mag = |Gx| + |Gy|, unsigned 12-bit, maximum 2040. No wrap permitted.
- Output geometry:
  - Output frame is shifted by one row and one column: the output pixel at input position (r,c) is centred on (r−1,c−1).
- Border rule: oPix is forced to 0 when any of these holds for the pixel that produced it:
  - row<2
  - col<2
  - col>=MAX_W
- Timing alignment: oHs/oVs/oDe are plain 3-stage delays of the inputs, independent of pixel data.
- Blanking: oPix is 0 whenever oDe=0.
- Reset mid-frame:
  - All outputs go to 0 immediately.
  - After release, the block stays correct starting from the next iVs low period.
  - The partial frame is undefined except that timing outputs remain delayed copies.
- Upstream 1-based x/y are not consumed; this block keeps its own counters.

Optional Feature:
- Macro: SOBEL_BINARY_EN.
- Defined: oPix = 8'hFF when mag >= THRESH, else 8'h00 (border rule still applies).
- Undefined: oPix = (mag > 255) ? 8'hFF : mag[7:0].

Test Plan:
- Flat frame, all pixels 8'd100, 50x50 → every oPix = 0; oDe pulses equal iDe pulses delayed exactly 3 cycles.
- Vertical step, cols 1–25 = 0 and cols 26–50 = 200, no macro → oPix = 255 (saturated, mag=800) at output cols 26 and 27 on rows >= 3; 0 elsewhere.
- Horizontal ramp, pixel = 4·col, no macro → interior oPix = 32 (Gx=32, Gy=0); rows 1–2 and cols 1–2 = 0.
- SOBEL_BINARY_EN, THRESH=32, same ramp → interior oPix = 8'hFF (equality passes). Repeat with THRESH=33 → all oPix = 0.
- rst_n pulsed low mid-line in frame 1 → oHs/oVs/oDe/oPix = 0 during reset; frame 2 output bit-exact with a clean-run golden.
- Line of 1030 active pixels with MAX_W=1024 → cols 1025–1030 give oPix = 0 and no counter wrap; next line's output remains correct.
